fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream_if.sv | 33 +++
 rtl/fifo_rd_stream.sv | 169 ++++++++++++++++
 tb/tb_fifo_rd_stream.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_if.sv
// Handshake bundle between an upstream sync FIFO read port, the read streamer
// and the downstream valid/ready sink.
interface fifo_rd_stream_if #(
  parameter int WIDTH = 8
);
  logic             fifo_empty_i;
  logic [WIDTH-1:0] fifo_rdata_i;
  logic             fifo_rd_en_o;
  logic             m_valid_o;
  logic             m_ready_i;
  logic [WIDTH-1:0] m_data_o;
  logic             m_last_o;

  modport master (
    input  fifo_empty_i,
    input  fifo_rdata_i,
    input  m_ready_i,
    output fifo_rd_en_o,
    output m_valid_o,
    output m_data_o,
    output m_last_o
  );

  modport slave (
    output fifo_empty_i,
    output fifo_rdata_i,
    output m_ready_i,
    input  fifo_rd_en_o,
    input  m_valid_o,
    input  m_data_o,
    input  m_last_o
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Converts a latency-1 sync FIFO read port into a valid/ready stream with a
// 2-entry skid buffer, PKT_LEN-beat last marking and a wrapping beat counter.
module fifo_rd_stream #(
  parameter int WIDTH   = 8,
  parameter int PKT_LEN = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               enable_i,
  fifo_rd_stream_if.master   bus,
  output logic [1:0]         state_o,
  output logic [15:0]        beats_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [15:0] PKT_LAST = 16'(PKT_LEN - 1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [1:0]       occ_r;
  logic [1:0]       occ_nxt_s;
  logic             infl_r;
  logic [WIDTH-1:0] buf0_r;
  logic [WIDTH-1:0] buf1_r;
  logic [WIDTH-1:0] buf0_nxt_s;
  logic [WIDTH-1:0] buf1_nxt_s;
  logic [15:0]      pkt_cnt_r;
  logic [15:0]      pkt_cnt_nxt_s;
  logic [15:0]      beats_r;
  logic [2:0]       load_s;
  logic             hs_s;
  logic             rd_en_s;
  logic             cap_s;
  logic             valid_s;

  assign valid_s          = (occ_r != 2'd0);
  assign hs_s             = valid_s & bus.m_ready_i;
  assign cap_s            = infl_r;
  assign load_s           = {1'b0, occ_r} + {2'b00, infl_r};

  assign bus.m_valid_o    = valid_s;
  assign bus.m_data_o     = buf0_r;
  assign bus.m_last_o     = valid_s & (pkt_cnt_r == PKT_LAST);
  assign bus.fifo_rd_en_o = rd_en_s;
  assign state_o          = state_r;
  assign beats_o          = beats_r;

  // Pop only while the buffer is guaranteed a free slot when the data lands.
  always_comb begin
    rd_en_s = 1'b0;
    if ((state_r == ST_RUN) && enable_i && !bus.fifo_empty_i) begin
      if (load_s < (3'd2 + {2'b00, hs_s})) begin
        rd_en_s = 1'b1;
      end else begin
        rd_en_s = 1'b0;
      end
    end else begin
      rd_en_s = 1'b0;
    end
  end

  // Skid buffer update: buf0 is always the oldest entry.
  always_comb begin
    occ_nxt_s  = occ_r;
    buf0_nxt_s = buf0_r;
    buf1_nxt_s = buf1_r;
    case ({cap_s, hs_s})
      2'b10: begin
        occ_nxt_s = occ_r + 2'd1;
        if (occ_r == 2'd0) begin
          buf0_nxt_s = bus.fifo_rdata_i;
        end else begin
          buf1_nxt_s = bus.fifo_rdata_i;
        end
      end
      2'b01: begin
        occ_nxt_s  = occ_r - 2'd1;
        buf0_nxt_s = buf1_r;
      end
      2'b11: begin
        if (occ_r == 2'd2) begin
          buf0_nxt_s = buf1_r;
          buf1_nxt_s = bus.fifo_rdata_i;
        end else begin
          buf0_nxt_s = bus.fifo_rdata_i;
        end
      end
      default: begin
        occ_nxt_s = occ_r;
      end
    endcase
  end

  // Packet position advances per handshake and survives enable drops.
  always_comb begin
    pkt_cnt_nxt_s = pkt_cnt_r;
    if (hs_s) begin
      if (pkt_cnt_r == PKT_LAST) begin
        pkt_cnt_nxt_s = 16'd0;
      end else begin
        pkt_cnt_nxt_s = pkt_cnt_r + 16'd1;
      end
    end else begin
      pkt_cnt_nxt_s = pkt_cnt_r;
    end
  end

  // Next-state logic; DRAIN exits once nothing is buffered or in flight.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable_i) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (enable_i) begin
          state_nxt_s = ST_RUN;
        end else if ((occ_r != 2'd0) || infl_r) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (enable_i) begin
          state_nxt_s = ST_RUN;
        end else if ((occ_nxt_s == 2'd0) && !rd_en_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset input is active-high and asynchronous.
  always_ff @(posedge clk_i or posedge rst_n_i) begin
    if (rst_n_i) begin
      state_r   <= ST_IDLE;
      occ_r     <= 2'd0;
      infl_r    <= 1'b0;
      buf0_r    <= {WIDTH{1'b0}};
      buf1_r    <= {WIDTH{1'b0}};
      pkt_cnt_r <= 16'd0;
      beats_r   <= 16'd0;
    end else begin
      state_r   <= state_nxt_s;
      occ_r     <= occ_nxt_s;
      infl_r    <= rd_en_s;
      buf0_r    <= buf0_nxt_s;
      buf1_r    <= buf1_nxt_s;
      pkt_cnt_r <= pkt_cnt_nxt_s;
      beats_r   <= beats_r + {15'd0, hs_s};
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: cycle table for streaming plus hand-built
// backpressure, drain, random, reset and counter-wrap sequences.
module tb_fifo_rd_stream;
  localparam int WIDTH   = 8;
  localparam int PKT_LEN = 4;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b1;
  logic        enable = 1'b0;
  logic        ready  = 1'b0;
  logic [1:0]  state;
  logic [15:0] beats;

  fifo_rd_stream_if #(.WIDTH(WIDTH)) bus ();

  fifo_rd_stream #(.WIDTH(WIDTH), .PKT_LEN(PKT_LEN)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .enable_i (enable),
    .bus      (bus),
    .state_o  (state),
    .beats_o  (beats)
  );

  always #5 clk = ~clk;

  // Upstream sync FIFO: data appears the cycle after a pop.
  logic [7:0] mem [0:255];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       flush  = 1'b0;
  logic [7:0] rdata  = 8'h00;

  assign bus.fifo_empty_i = (wr_ptr == rd_ptr);
  assign bus.fifo_rdata_i = rdata;
  assign bus.m_ready_i    = ready;

  always @(posedge clk) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (bus.fifo_rd_en_o && (wr_ptr != rd_ptr)) begin
      rdata  <= mem[rd_ptr[7:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

  int         checks   = 0;
  int         failures = 0;
  bit         sb_on    = 1'b0;
  logic [7:0] exp_q [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr[7:0]] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (state == 2'd0) break;
    end
    check("reach_idle", state, 32'd0);
  endtask

  // Continuous protocol monitor: no pop on empty, bounded outstanding data,
  // stable beat under backpressure, ordered data when the scoreboard is on.
  int         pops_m;
  int         hs_m;
  logic       prev_stall;
  logic [7:0] prev_data;
  initial begin
    pops_m = 0; hs_m = 0; prev_stall = 1'b0; prev_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        pops_m = 0; hs_m = 0; prev_stall = 1'b0;
      end else begin
        if (bus.fifo_rd_en_o) begin
          check("rd_on_empty", bus.fifo_empty_i, 32'd0);
          pops_m++;
        end
        if (prev_stall) begin
          check("stall_valid", bus.m_valid_o, 32'd1);
          check("stall_data", bus.m_data_o, prev_data);
        end
        if (bus.m_valid_o && bus.m_ready_i) begin
          hs_m++;
          if (sb_on) begin
            check("sb_nonempty", exp_q.size() > 0, 32'd1);
            if (exp_q.size() > 0) check("sb_data", bus.m_data_o, exp_q.pop_front());
          end
        end
        check("outstanding_le2", (pops_m - hs_m) <= 2, 32'd1);
        prev_stall = bus.m_valid_o && !bus.m_ready_i;
        prev_data  = bus.m_data_o;
      end
    end
  end

  typedef struct {
    logic        en;
    logic        rdy;
    logic        rd;
    logic        vld;
    logic [7:0]  data;
    logic        last;
    logic [1:0]  st;
    logic [15:0] bts;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #5_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    int         pops;
    int         k;
    int         n;
    logic [7:0] wv;

    // Streaming 0x01..0x08: two-cycle startup, then one beat per cycle.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 16'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd1, 16'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd1, 16'd0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 2'd1, 16'd0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h02, 1'b0, 2'd1, 16'd1};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 2'd1, 16'd2};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h04, 1'b1, 2'd1, 16'd3};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h05, 1'b0, 2'd1, 16'd4};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h06, 1'b0, 2'd1, 16'd5};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h07, 1'b0, 2'd1, 16'd6};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h08, 1'b1, 2'd1, 16'd7};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'd1, 16'd8};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 16'd8};

    repeat (2) @(posedge clk);
    #1;
    check("rst_state", state, 32'd0);
    check("rst_valid", bus.m_valid_o, 32'd0);
    check("rst_rd_en", bus.fifo_rd_en_o, 32'd0);
    check("rst_data", bus.m_data_o, 32'd0);
    check("rst_last", bus.m_last_o, 32'd0);
    check("rst_beats", beats, 32'd0);
    rst_n = 1'b0;

    for (int i = 1; i <= 8; i++) push(8'(i));
    for (int i = 0; i < 13; i++) begin
      enable = tbl[i].en;
      ready  = tbl[i].rdy;
      @(negedge clk);
      check($sformatf("tbl%0d_rd_en", i), bus.fifo_rd_en_o, 32'(tbl[i].rd));
      check($sformatf("tbl%0d_valid", i), bus.m_valid_o, 32'(tbl[i].vld));
      check($sformatf("tbl%0d_last", i), bus.m_last_o, 32'(tbl[i].last));
      check($sformatf("tbl%0d_state", i), state, 32'(tbl[i].st));
      check($sformatf("tbl%0d_beats", i), beats, 32'(tbl[i].bts));
      if (tbl[i].vld) check($sformatf("tbl%0d_data", i), bus.m_data_o, 32'(tbl[i].data));
      step();
    end

    // Backpressure: only two pops, head beat held, then full in-order release.
    for (int i = 0; i < 6; i++) push(8'(8'hA0 + i));
    enable = 1'b1;
    ready  = 1'b0;
    pops   = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.fifo_rd_en_o) pops++;
      if (c >= 4) begin
        check("bp_valid", bus.m_valid_o, 32'd1);
        check("bp_data", bus.m_data_o, 32'h0A0);
      end
      step();
    end
    check("bp_pops", pops, 32'd2);
    ready = 1'b1;
    k = 0;
    for (int c = 0; c < 20 && k < 6; c++) begin
      @(negedge clk);
      if (bus.m_valid_o) begin
        check("bp_rel_data", bus.m_data_o, 32'(8'hA0 + k));
        check("bp_rel_last", bus.m_last_o, 32'(k == 3));
        k++;
      end
      step();
    end
    check("bp_rel_count", k, 32'd6);
    enable = 1'b0;
    wait_idle(20);

    // Drain: enable drops with one beat buffered and one read in flight.
    for (int i = 0; i < 4; i++) push(8'(8'hB0 + i));
    enable = 1'b1;
    ready  = 1'b0;
    repeat (3) step();
    enable = 1'b0;
    @(negedge clk);
    check("drn_c3_state", state, 32'd1);
    check("drn_c3_rd_en", bus.fifo_rd_en_o, 32'd0);
    step();
    ready = 1'b1;
    @(negedge clk);
    check("drn_c4_state", state, 32'd2);
    check("drn_c4_rd_en", bus.fifo_rd_en_o, 32'd0);
    check("drn_c4_data", bus.m_data_o, 32'h0B0);
    check("drn_c4_last", bus.m_last_o, 32'd0);
    step();
    @(negedge clk);
    check("drn_c5_state", state, 32'd2);
    check("drn_c5_rd_en", bus.fifo_rd_en_o, 32'd0);
    check("drn_c5_data", bus.m_data_o, 32'h0B1);
    check("drn_c5_last", bus.m_last_o, 32'd1);
    step();
    @(negedge clk);
    check("drn_c6_state", state, 32'd0);
    check("drn_c6_valid", bus.m_valid_o, 32'd0);
    check("drn_c6_beats", beats, 32'd16);
    ready = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;

    // Random writes and backpressure against the ordered scoreboard.
    exp_q.delete();
    sb_on  = 1'b1;
    enable = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 9) < 3) begin
        wv = 8'($urandom);
        push(wv);
        exp_q.push_back(wv);
      end
      ready = 1'($urandom_range(0, 1));
      step();
    end
    ready = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) step();
    check("rand_drained", exp_q.size(), 32'd0);
    sb_on  = 1'b0;
    enable = 1'b0;
    wait_idle(20);

    // Asynchronous reset mid-stream, then restart and wrap the beat counter.
    for (int i = 0; i < 10; i++) push(8'(8'hC0 + i));
    enable = 1'b1;
    ready  = 1'b1;
    repeat (6) step();
    #2;
    rst_n = 1'b1;
    #1;
    check("mid_rst_state", state, 32'd0);
    check("mid_rst_valid", bus.m_valid_o, 32'd0);
    check("mid_rst_data", bus.m_data_o, 32'd0);
    check("mid_rst_last", bus.m_last_o, 32'd0);
    check("mid_rst_rd_en", bus.fifo_rd_en_o, 32'd0);
    check("mid_rst_beats", beats, 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      push(8'(8'hD0 + i));
      exp_q.push_back(8'(8'hD0 + i));
    end
    wv    = 8'hD8;
    sb_on = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    check("post_rst_rd_en", bus.fifo_rd_en_o, 32'd0);
    check("post_rst_state", state, 32'd0);
    step();
    n = 0;
    for (int c = 0; c < 70000 && n < 65538; c++) begin
      @(negedge clk);
      if (n == 65535 || n == 65536 || n == 65537) begin
        check($sformatf("wrap_beats_%0d", n), beats, 32'(n[15:0]));
      end
      if (bus.m_valid_o && bus.m_ready_i) begin
        if (n < 4) check($sformatf("post_rst_last_%0d", n), bus.m_last_o, 32'(n == 3));
        n++;
      end
      step();
      if ((wr_ptr - rd_ptr) < 8) begin
        push(wv);
        exp_q.push_back(wv);
        wv = wv + 8'd1;
      end
    end
    check("wrap_total", n, 32'd65538);
    sb_on  = 1'b0;
    enable = 1'b0;
    wait_idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
